// File: rtl/rs_latch_pkg.sv
// Shared constants and next-state helper for the gated set/reset flag bank.
package rs_latch_pkg;

  localparam int POL_HOLD   = 0;
  localparam int POL_SET    = 1;
  localparam int POL_RESET  = 2;
  localparam int POL_TOGGLE = 3;

  localparam int CNT_W = 16;

  // Resolves one bit's next value; s=r=1 is settled by the compile-time policy.
  function automatic logic nextBit(input logic q, input logic s, input logic r,
                                   input int policy);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (policy)
          POL_SET:    nxt = 1'b1;
          POL_RESET:  nxt = 1'b0;
          POL_TOGGLE: nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rs_latch_cell.sv
// Single gated S/R storage bit; requests only take effect on an enabled clock edge.
module rs_latch_cell
  import rs_latch_pkg::*;
#(
  parameter logic RESET_VALUE    = 1'b0,
  parameter int   INVALID_POLICY = POL_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VALUE;
    end else if (en) begin
      r_q <= nextBit(r_q, s, r, INVALID_POLICY);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/rs_latch_gated.sv
// Bank of WIDTH gated S/R flags with invalid-input pulse and sticky error.
// Optional invalid-event counter output inv_cnt when RS_LATCH_EVENT_CNT_EN is defined.
module rs_latch_gated
  import rs_latch_pkg::*;
#(
  parameter int               WIDTH          = 1,
  parameter int               INVALID_POLICY = POL_HOLD,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             invalid,
  output logic             err_sticky,
  input  logic             err_clr
`ifdef RS_LATCH_EVENT_CNT_EN
  ,
  output logic [CNT_W-1:0] inv_cnt
`endif
);

  logic [WIDTH-1:0] w_q;
  logic             w_event;
  logic             r_invalid;
  logic             r_err;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    rs_latch_cell #(
      .RESET_VALUE   (RESET_VALUE[i]),
      .INVALID_POLICY(INVALID_POLICY)
    ) uCell (
      .clk(clk),
      .rst(rst),
      .en (en),
      .s  (s[i]),
      .r  (r[i]),
      .q  (w_q[i])
    );
  end

  assign w_event = en & (|(s & r));

  // A new event outranks a same-cycle clear so no violation is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_invalid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_invalid <= w_event;
      r_err     <= (r_err & ~err_clr) | w_event;
    end
  end

  assign q          = w_q;
  assign nq         = ~w_q;
  assign invalid    = r_invalid;
  assign err_sticky = r_err;

`ifdef RS_LATCH_EVENT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (err_clr) begin
      r_cnt <= {{(CNT_W-1){1'b0}}, w_event};
    end else if (w_event && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign inv_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_rs_latch_gated.sv
// Self-checking bench: four WIDTH=4 instances, one per invalid policy, against a behavioural model.
// Checks inv_cnt as well when RS_LATCH_EVENT_CNT_EN is defined.
module tb_rs_latch_gated;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       errClr;

  logic [3:0]  qv   [4];
  logic [3:0]  nqv  [4];
  logic        invv [4];
  logic        errv [4];
`ifdef RS_LATCH_EVENT_CNT_EN
  logic [15:0] cntv [4];
`endif

  int assertCount = 0;
  int failCount   = 0;

  // Reference state, computed straight from the set/reset rules.
  logic [3:0]  mq [4];
  logic        mInv;
  logic        mErr;
  logic [15:0] mCnt;

  for (genvar k = 0; k < 4; k++) begin : gDut
    rs_latch_gated #(
      .WIDTH         (4),
      .INVALID_POLICY(k),
      .RESET_VALUE   (4'(k * 5))
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .s         (s),
      .r         (r),
      .q         (qv[k]),
      .nq        (nqv[k]),
      .invalid   (invv[k]),
      .err_sticky(errv[k]),
      .err_clr   (errClr)
`ifdef RS_LATCH_EVENT_CNT_EN
      ,
      .inv_cnt   (cntv[k])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rv(input int k);
    return 4'(k * 5);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 4; k++) mq[k] = rv(k);
    mInv = 1'b0;
    mErr = 1'b0;
    mCnt = 16'd0;
  endtask

  // Advance one rising edge, update the model from the sampled inputs, then settle.
  task automatic tick();
    logic ev;
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      ev = en && ((s & r) != 4'b0000);
      for (int k = 0; k < 4; k++) begin
        if (en) begin
          for (int i = 0; i < 4; i++) begin
            if (s[i] && !r[i])      mq[k][i] = 1'b1;
            else if (!s[i] && r[i]) mq[k][i] = 1'b0;
            else if (s[i] && r[i]) begin
              if (k == 1)      mq[k][i] = 1'b1;
              else if (k == 2) mq[k][i] = 1'b0;
              else if (k == 3) mq[k][i] = ~mq[k][i];
            end
          end
        end
      end
      mInv = ev;
      mErr = (mErr && !errClr) || ev;
      if (errClr)                    mCnt = ev ? 16'd1 : 16'd0;
      else if (ev && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    end
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] sv, input logic [3:0] rvv,
                       input logic c);
    en = e; s = sv; r = rvv; errClr = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    modelReset();
    #3;
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== rv(k) || nqv[k] !== ~rv(k) || invv[k] !== 1'b0 || errv[k] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_initial dut%0d q=%b nq=%b inv=%b err=%b required q=%b nq=%b inv=0 err=0",
                 k, qv[k], nqv[k], invv[k], errv[k], rv(k), ~rv(k));
      end
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 4'hF, 4'h1, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== rv(k) || nqv[k] !== ~rv(k) || invv[k] !== 1'b0 || errv[k] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_async dut%0d q=%b nq=%b inv=%b err=%b required q=%b nq=%b inv=0 err=0",
                 k, qv[k], nqv[k], invv[k], errv[k], rv(k), ~rv(k));
      end
    end
    drive(1'b1, 4'hF, 4'h0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== rv(k)) begin
        failCount++;
        $display("[TB] FAIL reset_discard dut%0d q=%b required %b", k, qv[k], rv(k));
      end
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== 4'hF || qv[k] !== mq[k] || nqv[k] !== 4'h0) begin
        failCount++;
        $display("[TB] FAIL reset_release dut%0d q=%b nq=%b required q=1111 nq=0000", k, qv[k], nqv[k]);
      end
    end
  endtask

  task automatic test_gating();
    drive(1'b1, 4'h0, 4'hF, 1'b1);
    tick();
    drive(1'b0, 4'h1, 4'h0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        assertCount++;
        if (qv[k] !== 4'h0 || qv[k] !== mq[k]) begin
          failCount++;
          $display("[TB] FAIL gating_hold dut%0d edge%0d q=%b required 0000", k, n, qv[k]);
        end
      end
    end
    en = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== 4'h1 || nqv[k] !== 4'hE) begin
        failCount++;
        $display("[TB] FAIL gating_enable dut%0d q=%b nq=%b required q=0001 nq=1110", k, qv[k], nqv[k]);
      end
    end
  endtask

  task automatic test_sequence();
    logic [3:0] stepS [4] = '{4'hF, 4'h0, 4'h0, 4'h0};
    logic [3:0] stepR [4] = '{4'h0, 4'h0, 4'hF, 4'h0};
    logic [3:0] stepQ [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
    for (int st = 0; st < 4; st++) begin
      for (int ph = 0; ph < 2; ph++) begin
        drive(ph == 0, stepS[st], stepR[st], 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
          assertCount++;
          if (qv[k] !== stepQ[st] || qv[k] !== mq[k] || invv[k] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sequence dut%0d step%0d ph%0d q=%b inv=%b required q=%b inv=0",
                     k, st, ph, qv[k], invv[k], stepQ[st]);
          end
        end
      end
    end
  endtask

  task automatic test_forbidden();
    logic [3:0] exp1 [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
    logic [3:0] exp2 [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
    drive(1'b1, 4'h0, 4'hF, 1'b1);
    tick();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== exp1[k] || invv[k] !== 1'b1 || errv[k] !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL forbidden_edge1 dut%0d q=%b inv=%b err=%b required q=%b inv=1 err=1",
                 k, qv[k], invv[k], errv[k], exp1[k]);
      end
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== exp2[k] || qv[k] !== mq[k]) begin
        failCount++;
        $display("[TB] FAIL forbidden_edge2 dut%0d q=%b required %b", k, qv[k], exp2[k]);
      end
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (invv[k] !== 1'b0 || errv[k] !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL forbidden_sticky dut%0d inv=%b err=%b required inv=0 err=1", k, invv[k], errv[k]);
      end
    end
    errClr = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (errv[k] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL forbidden_clear dut%0d err=%b required 0", k, errv[k]);
      end
    end
  endtask

  task automatic test_gated_forbidden();
    logic [3:0] qBefore [4];
    for (int k = 0; k < 4; k++) qBefore[k] = qv[k];
    drive(1'b0, 4'hF, 4'hF, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (invv[k] !== 1'b0 || errv[k] !== 1'b0 || qv[k] !== qBefore[k]) begin
        failCount++;
        $display("[TB] FAIL gated_forbidden dut%0d inv=%b err=%b q=%b required inv=0 err=0 q=%b",
                 k, invv[k], errv[k], qv[k], qBefore[k]);
      end
    end
    drive(1'b1, 4'h2, 4'h2, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (errv[k] !== 1'b1 || invv[k] !== 1'b1 || qv[k] !== mq[k]) begin
        failCount++;
        $display("[TB] FAIL clear_vs_event dut%0d err=%b inv=%b q=%b required err=1 inv=1 q=%b",
                 k, errv[k], invv[k], qv[k], mq[k]);
      end
`ifdef RS_LATCH_EVENT_CNT_EN
      assertCount++;
      if (cntv[k] !== 16'd1) begin
        failCount++;
        $display("[TB] FAIL cnt_clear_vs_event dut%0d cnt=%0d required 1", k, cntv[k]);
      end
`endif
    end
  endtask

  task automatic test_multibit();
    logic [3:0] expQ [4] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101};
    drive(1'b1, 4'h0, 4'hF, 1'b1);
    tick();
    drive(1'b1, 4'b0101, 4'b0011, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (qv[k] !== expQ[k] || qv[k] !== mq[k] || invv[k] !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL multibit dut%0d q=%b inv=%b required q=%b inv=1", k, qv[k], invv[k], expQ[k]);
      end
`ifdef RS_LATCH_EVENT_CNT_EN
      assertCount++;
      if (cntv[k] !== 16'd1) begin
        failCount++;
        $display("[TB] FAIL multibit_cnt dut%0d cnt=%0d required 1", k, cntv[k]);
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        assertCount++;
        if (qv[k] !== mq[k] || nqv[k] !== ~mq[k] || invv[k] !== mInv || errv[k] !== mErr) begin
          failCount++;
          $display("[TB] FAIL random dut%0d cyc%0d q=%b nq=%b inv=%b err=%b required q=%b nq=%b inv=%b err=%b",
                   k, n, qv[k], nqv[k], invv[k], errv[k], mq[k], ~mq[k], mInv, mErr);
        end
`ifdef RS_LATCH_EVENT_CNT_EN
        assertCount++;
        if (cntv[k] !== mCnt) begin
          failCount++;
          $display("[TB] FAIL random_cnt dut%0d cyc%0d cnt=%0d required %0d", k, n, cntv[k], mCnt);
        end
`endif
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gating();
    test_sequence();
    test_forbidden();
    test_gated_forbidden();
    test_multibit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rs_latch_gated.md
Name: rs_latch_gated

Overview:
- Bank of WIDTH gated set/reset storage bits, each with a complementary output.
- Inputs are sampled on the clock only while enable is high.
- The forbidden S=R=1 input combination is resolved by a compile-time policy and reported through a per-cycle flag and a sticky error flag.
- Used as a generic control-flag store: status bits, mode latches and interrupt-style set/clear flags.

Parameters:
- WIDTH, 1, number of independent S/R bits.
- INVALID_POLICY, 0, action on S=R=1 with en=1: 0=HOLD, 1=SET, 2=RESET, 3=TOGGLE.
- RESET_VALUE, 0, value of q after reset (WIDTH bits; nq resets to its complement).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  gate; S/R are only honoured when en=1 at a rising clk edge
- s  in  WIDTH  per-bit set request
- r  in  WIDTH  per-bit reset request
- q  out  WIDTH  stored value
- nq  out  WIDTH  always exactly ~q
- invalid  out  1  registered pulse, 1 for one cycle after any bit saw s=r=1 with en=1
- err_sticky  out  1  set by any invalid event, held until err_clr or rst
- err_clr  in  1  synchronous clear of err_sticky

Behaviour:
- Reset (rst=1, asynchronous, dominant over everything):
  - q=RESET_VALUE, nq=~RESET_VALUE, invalid=0, err_sticky=0.
- Per bit i, at rising clk with rst=0:
  - en=0: q[i] holds, regardless of s and r.
  - en=1, s=1 r=0: q[i]<=1.
  - en=1, s=0 r=1: q[i]<=0.
  - en=1, s=0 r=0: q[i] holds.
  - en=1, s=1 r=1: q[i] follows INVALID_POLICY (HOLD keeps, SET ->1, RESET ->0, TOGGLE ->~q[i]).
- Latency: one clk; q changes at the edge that samples en=1 with the request.
- nq is combinational ~q, never equal to q, including during and immediately after reset.
- invalid <= en & |(s & r), registered; it is 0 on any cycle where en=0.
- err_sticky:
  - err_sticky <= (err_sticky & ~err_clr) | (en & |(s & r)).
  - When err_clr and a new invalid event occur in the same cycle, the new event wins and err_sticky stays 1.
- Bits are fully independent; an invalid event on one bit does not affect the others.
- Reset asserted mid-request discards the request. After deassertion the next qualifying en=1 edge acts normally.
- Inputs are assumed synchronous to clk; the block contains no internal synchronizers.

Optional Feature:
- Macro RS_LATCH_EVENT_CNT_EN.
- When defined:
  - Adds output inv_cnt [15:0], counting clock cycles with an invalid event.
  - inv_cnt saturates at 16'hFFFF.
  - inv_cnt resets to 0 on rst and clears to 0 on err_clr. If err_clr and an event coincide, inv_cnt becomes 1.
- When undefined: the port and counter are absent and all other behaviour is identical.

Decomposition:
- Package rs_latch_pkg: policy constants POL_HOLD=0, POL_SET=1, POL_RESET=2, POL_TOGGLE=3, plus the counter width constant 16.
- Sub-module rs_latch_cell: one bit with inputs clk, rst, en, s, r and output q, plus its reset value and policy. It is instantiated WIDTH times by a generate loop.
- Error, flag and counter logic stay in the top level.

Test Plan:
- Reset: assert rst mid-cycle with WIDTH=1, RESET_VALUE=0 -> q=0, nq=1, invalid=0, err_sticky=0 immediately, without waiting for a clk edge.
- Gating: en=0, s=1, r=0 for 3 edges -> q stays 0. Raise en=1 -> q=1 after the next edge, nq=0.
- Sequence with en toggling every cycle:
  - s=1,r=0, then s=0,r=0 -> q=1 held.
  - s=0,r=1 -> q=0 at the first en=1 edge.
  - s=0,r=0 -> q=0 held.
- Forbidden input, s=1,r=1,en=1 with q=0:
  - INVALID_POLICY=0 -> q=0.
  - INVALID_POLICY=1 -> q=1.
  - INVALID_POLICY=3 toggles each edge: q=1 then 0.
  - In every case invalid=1 for one cycle and err_sticky=1 until err_clr.
- Forbidden input with en=0 -> invalid=0, err_sticky=0, q unchanged. Then err_clr together with a new event -> err_sticky stays 1.
- WIDTH=4, s=4'b0101, r=4'b0011, en=1, from q=0:
  - HOLD -> q=4'b0100, invalid=1.
  - With RS_LATCH_EVENT_CNT_EN defined, inv_cnt increments to 1.
